// File: rtl/io_input_conditioner.sv
// rtl/io_input_conditioner.sv - synchronizer, per-bit debounce, sticky key-press flags and press counter (optional irq via IO_COND_IRQ_EN)
module io_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] keyRaw,
    input  logic [N_SW-1:0]   swRaw,
    input  logic              clrEn,
    input  logic [N_KEYS-1:0] clrMask,
    output logic [N_KEYS-1:0] keyLvl,
    output logic [N_SW-1:0]   swLvl,
    output logic [N_KEYS-1:0] keyPress,
    output logic [7:0]        pressCnt,
    output logic              irq
);

    localparam int N  = N_KEYS + N_SW;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] key_meta, key_sync;
    logic [N_SW-1:0]   sw_meta, sw_sync;
    logic [N-1:0]      s, lvl, lvl_nxt;
    logic [CW-1:0]     cnt     [N];
    logic [CW-1:0]     cnt_nxt [N];
    logic [N_KEYS-1:0] key_rise, clr_bits;
    logic [7:0]        press_add;

    // Two-flop synchronizers; keys idle released (high), switches idle low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= '1;
            key_sync <= '1;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= keyRaw;
            key_sync <= key_meta;
            sw_meta  <= swRaw;
            sw_sync  <= sw_meta;
        end
    end

    // Keys share the debounce array with switches; keys occupy the low bits, inverted to active-high
    assign s = {sw_sync, ~key_sync};

    // Next stable level and counter: count consecutive differing samples, adopt the sample on the last one
    always_comb begin
        for (int i = 0; i < N; i++) begin
            lvl_nxt[i] = lvl[i];
            cnt_nxt[i] = '0;
            if (s[i] != lvl[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    lvl_nxt[i] = s[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            lvl <= lvl_nxt;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Rising edges taken from the next level so flags and count move on the same edge as keyLvl
    assign key_rise = lvl_nxt[N_KEYS-1:0] & ~lvl[N_KEYS-1:0];
    assign clr_bits = clrEn ? clrMask : '0;

    // Number of keys rising this cycle
    always_comb begin
        press_add = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            press_add = press_add + 8'(key_rise[i]);
        end
    end

    // Sticky flags (set beats clear) and wrapping press counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keyPress <= '0;
            pressCnt <= '0;
        end else begin
            keyPress <= (keyPress & ~clr_bits) | key_rise;
            pressCnt <= pressCnt + press_add;
        end
    end

    assign keyLvl = lvl[N_KEYS-1:0];
    assign swLvl  = lvl[N-1:N_KEYS];

`ifdef IO_COND_IRQ_EN
    // Interrupt follows the flags one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |keyPress;
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// tb/tb_io_input_conditioner.sv - directed self-checking bench for io_input_conditioner
module tb_io_input_conditioner;

    logic       clk;
    logic       rst_n;
    logic [3:0] keyRaw;
    logic [9:0] swRaw;
    logic       clrEn;
    logic [3:0] clrMask;
    logic [3:0] keyLvl;
    logic [9:0] swLvl;
    logic [3:0] keyPress;
    logic [7:0] pressCnt;
    logic       irq;

    int checks   = 0;
    int failures = 0;
    logic exp_irq_on;

    io_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .N_KEYS(4),
        .N_SW(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .keyRaw(keyRaw),
        .swRaw(swRaw),
        .clrEn(clrEn),
        .clrMask(clrMask),
        .keyLvl(keyLvl),
        .swLvl(swLvl),
        .keyPress(keyPress),
        .pressCnt(pressCnt),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef IO_COND_IRQ_EN
        exp_irq_on = 1'b1;
`else
        exp_irq_on = 1'b0;
`endif
        rst_n   = 1'b0;
        keyRaw  = 4'hF;
        swRaw   = '0;
        clrEn   = 1'b0;
        clrMask = '0;
        cyc(3);
        check("rst_keyLvl", 32'(keyLvl), 32'h0);
        check("rst_swLvl", 32'(swLvl), 32'h0);
        check("rst_keyPress", 32'(keyPress), 32'h0);
        check("rst_pressCnt", 32'(pressCnt), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;

        // Idle keys released: nothing moves
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("idle_keyLvl", 32'(keyLvl), 32'h0);
            check("idle_keyPress", 32'(keyPress), 32'h0);
            check("idle_pressCnt", 32'(pressCnt), 32'h0);
        end

        // Key 1 pressed: level appears after exactly 6 edges
        keyRaw = 4'b1101;
        cyc(5);
        check("k1_early_keyLvl", 32'(keyLvl), 32'h0);
        check("k1_early_keyPress", 32'(keyPress), 32'h0);
        cyc(1);
        check("k1_keyLvl", 32'(keyLvl), 32'b0010);
        check("k1_keyPress", 32'(keyPress), 32'b0010);
        check("k1_pressCnt", 32'(pressCnt), 32'd1);
        check("k1_irq_same_edge", 32'(irq), 32'h0);
        cyc(1);
        check("k1_irq_next_edge", 32'(irq), 32'(exp_irq_on));
        check("k1_pressCnt_hold", 32'(pressCnt), 32'd1);

        // Switch 3 glitch of 3 samples never reaches the output
        swRaw = 10'b0000001000;
        cyc(3);
        swRaw = '0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("sw_glitch", 32'(swLvl), 32'h0);
        end
        swRaw = 10'b0000001000;
        cyc(5);
        check("sw3_early", 32'(swLvl), 32'h0);
        cyc(1);
        check("sw3_level", 32'(swLvl), 32'b0000001000);

        // Key 0 pressed too: flags 0011
        keyRaw = 4'b1100;
        cyc(6);
        check("k0_keyPress", 32'(keyPress), 32'b0011);
        check("k0_pressCnt", 32'(pressCnt), 32'd2);

        // Clear only flag 0
        clrEn   = 1'b1;
        clrMask = 4'b0001;
        cyc(1);
        clrEn   = 1'b0;
        clrMask = '0;
        check("clr0_keyPress", 32'(keyPress), 32'b0010);
        cyc(1);
        check("clr0_irq_stays", 32'(irq), 32'(exp_irq_on));

        // Release key 0, then a new press coinciding with a clear of flag 0: set wins
        keyRaw = 4'b1101;
        cyc(8);
        check("k0_released", 32'(keyLvl), 32'b0010);
        check("k0_release_noflag", 32'(keyPress), 32'b0010);
        keyRaw = 4'b1100;
        cyc(5);
        clrEn   = 1'b1;
        clrMask = 4'b0001;
        cyc(1);
        clrEn   = 1'b0;
        clrMask = '0;
        check("setwins_keyLvl", 32'(keyLvl), 32'b0011);
        check("setwins_keyPress", 32'(keyPress), 32'b0011);
        check("setwins_pressCnt", 32'(pressCnt), 32'd3);

        // Clear every flag: irq drops one edge later
        cyc(1);
        clrEn   = 1'b1;
        clrMask = 4'b1111;
        cyc(1);
        clrEn   = 1'b0;
        clrMask = '0;
        check("clrall_keyPress", 32'(keyPress), 32'h0);
        check("clrall_irq_same_edge", 32'(irq), 32'(exp_irq_on));
        cyc(1);
        check("clrall_irq_next_edge", 32'(irq), 32'h0);

        // Reset in the middle of a debounce discards the partial count
        keyRaw = 4'hF;
        cyc(10);
        keyRaw = 4'b0111;
        cyc(4);
        rst_n = 1'b0;
        cyc(1);
        check("midrst_keyLvl", 32'(keyLvl), 32'h0);
        check("midrst_pressCnt", 32'(pressCnt), 32'h0);
        rst_n = 1'b1;
        cyc(5);
        check("midrst_early", 32'(keyLvl), 32'h0);
        cyc(1);
        check("midrst_keyLvl_late", 32'(keyLvl), 32'b1000);
        check("midrst_pressCnt_late", 32'(pressCnt), 32'd1);

        // Clean restart for the counter wrap test
        keyRaw = 4'hF;
        rst_n  = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        for (int i = 1; i <= 256; i++) begin
            keyRaw = 4'b1011;
            cyc(6);
            check("wrap_pressCnt", 32'(pressCnt), 32'(i % 256));
            keyRaw = 4'hF;
            cyc(6);
            check("wrap_release", 32'(keyLvl), 32'h0);
        end
        check("wrap_zero", 32'(pressCnt), 32'h0);

        // Keys 2 and 3 together count twice
        keyRaw = 4'b0011;
        cyc(6);
        check("dual_keyLvl", 32'(keyLvl), 32'b1100);
        check("dual_pressCnt", 32'(pressCnt), 32'd2);
        check("dual_keyPress", 32'(keyPress), 32'b1100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
